// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer pair and
// sync_fifo_param. The sticky error signals (err_clr, overflow, underflow)
// only exist when FIFO_ERR_EN is defined.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              wr_en;
    logic [DATA_W-1:0] buf_in;
    logic              rd_en;
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty;
    logic              buf_full;
    logic              almost_empty;
    logic              almost_full;
    logic [CNT_W-1:0]  fifo_counter;
`ifdef FIFO_ERR_EN
    logic              err_clr;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side
    modport master (
        output wr_en, buf_in, rd_en, err_clr,
        input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  wr_en, buf_in, rd_en, err_clr,
        output buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter, overflow, underflow
    );
`else
    // Producer/consumer side
    modport master (
        output wr_en, buf_in, rd_en,
        input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter
    );

    // FIFO side
    modport slave (
        input  wr_en, buf_in, rd_en,
        output buf_out, buf_empty, buf_full, almost_empty, almost_full,
               fifo_counter
    );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, programmable
// almost-full/almost-empty thresholds and read+write while full.
// Optional feature macro: FIFO_ERR_EN adds sticky overflow/underflow flags
// with an err_clr input. Reset (rst) is synchronous and active-low.
module sync_fifo_param #(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = 14,
    parameter  int AE_LEVEL = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);

    // Storage is left unreset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] buf_out_reg;

    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;

    // Status decode straight from the occupancy counter.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // Accept decisions. A write while full only goes through when the read in
    // the same cycle frees a slot; a read while empty is always refused, so
    // an empty FIFO with both requests takes just the write (no bypass).
    always_comb begin
        rd_acc = bus.rd_en & ~empty;
        wr_acc = bus.wr_en & (~full | bus.rd_en);
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= bus.buf_in;
        end
    end

    // Pointers, occupancy and registered read data; reset takes priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            buf_out_reg <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                buf_out_reg <= mem[rd_ptr_reg];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.buf_out      = buf_out_reg;
    assign bus.fifo_counter = count_reg;
    assign bus.buf_empty    = empty;
    assign bus.buf_full     = full;
    assign bus.almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign bus.almost_full  = (count_reg >= CNT_W'(AF_LEVEL));

`ifdef FIFO_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    // Sticky error flags: a new error in the same cycle beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (bus.wr_en & ~wr_acc) begin
                overflow_reg <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (bus.rd_en & empty) begin
                underflow_reg <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus a random
// run, all checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_out;
    logic              exp_ovf;
    logic              exp_udf;

    int errors = 0;
    int checks = 0;

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic step(input logic w, input logic [DATA_W-1:0] d,
                        input logic r, input logic c);
        logic rd_ok;
        logic wr_ok;
        bus.wr_en  = w;
        bus.buf_in = d;
        bus.rd_en  = r;
`ifdef FIFO_ERR_EN
        bus.err_clr = c;
`endif
        rd_ok = r && (q.size() != 0);
        wr_ok = w && ((q.size() < DEPTH) || r);
        if (c) begin
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end
        if (w && !wr_ok) exp_ovf = 1'b1;
        if (r && q.size() == 0) exp_udf = 1'b1;
        @(posedge clk);
        #1;
        if (rd_ok) exp_out = q.pop_front();
        if (wr_ok) q.push_back(d);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
`ifdef FIFO_ERR_EN
        bus.err_clr = 1'b0;
`endif
    endtask

    // Reset for one edge, optionally with requests pending.
    task automatic do_reset(input logic w, input logic r);
        rst       = 1'b0;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.buf_in = 8'hEE;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        q.delete();
        exp_out = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0, 1'b0);
        checks++; if (bus.fifo_counter !== CNT_W'(0)) begin errors++;
            $display("FAIL reset_count got=%0d exp=0", bus.fifo_counter); end
        checks++; if (bus.buf_out !== 8'h00) begin errors++;
            $display("FAIL reset_out got=%h exp=00", bus.buf_out); end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++;
            $display("FAIL reset_empty got=%b exp=1", bus.buf_empty); end
        checks++; if (bus.buf_full !== 1'b0) begin errors++;
            $display("FAIL reset_full got=%b exp=0", bus.buf_full); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++;
            $display("FAIL reset_ae got=%b exp=1", bus.almost_empty); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++;
            $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
`ifdef FIFO_ERR_EN
        checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++;
            $display("FAIL reset_err got=%b%b exp=00", bus.overflow, bus.underflow); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
            checks++; if (bus.fifo_counter !== CNT_W'(i + 1)) begin errors++;
                $display("FAIL fill_count got=%0d exp=%0d", bus.fifo_counter, i + 1); end
        end
        checks++; if (bus.buf_full !== 1'b1) begin errors++;
            $display("FAIL fill_full got=%b exp=1", bus.buf_full); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (bus.buf_out !== DATA_W'(i + 1)) begin errors++;
                $display("FAIL drain_out got=%h exp=%h", bus.buf_out, DATA_W'(i + 1)); end
            checks++; if (bus.fifo_counter !== CNT_W'(DEPTH - 1 - i)) begin errors++;
                $display("FAIL drain_count got=%0d exp=%0d", bus.fifo_counter, DEPTH - 1 - i); end
        end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++;
            $display("FAIL drain_empty got=%b exp=1", bus.buf_empty); end
        $display("test_fill_drain done");
    endtask

    task automatic test_thresholds;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < AF_LEVEL - 1; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        checks++; if (bus.almost_full !== 1'b0) begin errors++;
            $display("FAIL af_below got=%b exp=0 count=%0d", bus.almost_full, bus.fifo_counter); end
        step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        checks++; if (bus.almost_full !== 1'b1) begin errors++;
            $display("FAIL af_at got=%b exp=1 count=%0d", bus.almost_full, bus.fifo_counter); end
        while (q.size() > AE_LEVEL + 1) step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.almost_empty !== 1'b0) begin errors++;
            $display("FAIL ae_above got=%b exp=0 count=%0d", bus.almost_empty, bus.fifo_counter); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.almost_empty !== 1'b1) begin errors++;
            $display("FAIL ae_at got=%b exp=1 count=%0d", bus.almost_empty, bus.fifo_counter); end
        checks++; if (bus.fifo_counter !== CNT_W'(AE_LEVEL)) begin errors++;
            $display("FAIL ae_count got=%0d exp=%0d", bus.fifo_counter, AE_LEVEL); end
        $display("test_thresholds done");
    endtask

    task automatic test_full_rw;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++; if (bus.fifo_counter !== CNT_W'(DEPTH)) begin errors++;
            $display("FAIL full_rw_count got=%0d exp=%0d", bus.fifo_counter, DEPTH); end
        checks++; if (bus.buf_out !== 8'h10) begin errors++;
            $display("FAIL full_rw_out got=%h exp=10", bus.buf_out); end
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== 8'hAA) begin errors++;
            $display("FAIL full_rw_last got=%h exp=aa", bus.buf_out); end
        $display("test_full_rw done");
    endtask

    task automatic test_empty_rw;
        do_reset(1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (bus.fifo_counter !== CNT_W'(1)) begin errors++;
            $display("FAIL empty_rw_count got=%0d exp=1", bus.fifo_counter); end
        checks++; if (bus.buf_out !== 8'h00) begin errors++;
            $display("FAIL empty_rw_out got=%h exp=00", bus.buf_out); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== 8'h55) begin errors++;
            $display("FAIL empty_rw_next got=%h exp=55", bus.buf_out); end
        $display("test_empty_rw done");
    endtask

    task automatic test_wrap;
        logic [DATA_W-1:0] d;
        do_reset(1'b0, 1'b0);
        d = 8'h30;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, d, 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (bus.buf_out !== d) begin errors++;
                $display("FAIL wrap_out iter=%0d got=%h exp=%h", i, bus.buf_out, d); end
            d = d + 8'd1;
        end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++;
            $display("FAIL wrap_empty got=%b exp=1", bus.buf_empty); end
        $display("test_wrap done");
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 55), DATA_W'($urandom),
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 9) == 0));
            n = q.size();
            checks++; if (bus.buf_out !== exp_out || bus.fifo_counter !== CNT_W'(n)) begin
                errors++;
                $display("FAIL rand_data cyc=%0d got out=%h cnt=%0d exp out=%h cnt=%0d",
                         i, bus.buf_out, bus.fifo_counter, exp_out, n); end
            checks++; if (bus.buf_empty !== (n == 0) || bus.buf_full !== (n == DEPTH) ||
                          bus.almost_empty !== (n <= AE_LEVEL) ||
                          bus.almost_full !== (n >= AF_LEVEL)) begin
                errors++;
                $display("FAIL rand_flags cyc=%0d got e/f/ae/af=%b%b%b%b for count %0d",
                         i, bus.buf_empty, bus.buf_full, bus.almost_empty, bus.almost_full, n); end
`ifdef FIFO_ERR_EN
            checks++; if (bus.overflow !== exp_ovf || bus.underflow !== exp_udf) begin errors++;
                $display("FAIL rand_err cyc=%0d got=%b%b exp=%b%b",
                         i, bus.overflow, bus.underflow, exp_ovf, exp_udf); end
`endif
        end
        $display("test_random done");
    endtask

`ifdef FIFO_ERR_EN
    task automatic test_errors;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        checks++; if (bus.overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        checks++; if (bus.fifo_counter !== CNT_W'(DEPTH)) begin errors++;
            $display("FAIL ovf_count got=%0d exp=%0d", bus.fifo_counter, DEPTH); end
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== DATA_W'(DEPTH - 1)) begin errors++;
            $display("FAIL ovf_dropped got=%h exp=%h", bus.buf_out, DATA_W'(DEPTH - 1)); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b1) begin errors++;
            $display("FAIL udf_set got=%b%b exp=11", bus.overflow, bus.underflow); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin errors++;
            $display("FAIL err_clr got=%b%b exp=00", bus.overflow, bus.underflow); end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++; if (bus.underflow !== 1'b1) begin errors++;
            $display("FAIL set_beats_clr got=%b exp=1", bus.underflow); end
        step(1'b0, '0, 1'b0, 1'b1);
        $display("test_errors done");
    endtask
`endif

    task automatic test_reset_mid;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        do_reset(1'b1, 1'b1);
        checks++; if (bus.fifo_counter !== CNT_W'(0)) begin errors++;
            $display("FAIL mid_rst_count got=%0d exp=0", bus.fifo_counter); end
        checks++; if (bus.buf_out !== 8'h00) begin errors++;
            $display("FAIL mid_rst_out got=%h exp=00", bus.buf_out); end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++;
            $display("FAIL mid_rst_empty got=%b exp=1", bus.buf_empty); end
        step(1'b1, 8'h9D, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== 8'h9D) begin errors++;
            $display("FAIL mid_rst_after got=%h exp=9d", bus.buf_out); end
        $display("test_reset_mid done");
    endtask

    initial begin
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.buf_in = '0;
`ifdef FIFO_ERR_EN
        bus.err_clr = 1'b0;
`endif
        exp_out = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_random();
`ifdef FIFO_ERR_EN
        test_errors();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO, the successor to the team's fixed 8-bit × 4-entry buffer. It adds configurable width and depth, programmable almost-full and almost-empty flags, and simultaneous read/write while full. It also adds optional sticky overflow/underflow error reporting. It sits between producer and consumer blocks in the same clock domain and keeps the existing port naming and registered-read behaviour.

## Interface
- DATA_W, 8: data width in bits (≥1).
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, 14: almost_full asserts when occupancy ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when occupancy ≤ AE_LEVEL (0..DEPTH-1).
- Derived: PTR_W = $clog2(DEPTH); CNT_W = PTR_W+1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- buf_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- buf_out  out  DATA_W  registered read data.
- buf_empty  out  1  occupancy == 0.
- buf_full  out  1  occupancy == DEPTH.
- almost_empty  out  1  occupancy ≤ AE_LEVEL.
- almost_full  out  1  occupancy ≥ AF_LEVEL.
- fifo_counter  out  CNT_W  current occupancy, 0..DEPTH.
- err_clr  in  1  clears sticky errors (only with FIFO_ERR_EN).
- overflow  out  1  sticky: write rejected (only with FIFO_ERR_EN).
- underflow  out  1  sticky: read rejected (only with FIFO_ERR_EN).

## Operation
- Storage is a DEPTH × DATA_W array. Memory is not reset.
- Pointers are wr_ptr and rd_ptr, PTR_W bits each. They wrap naturally from DEPTH-1 to 0.
- Read accept: rd_acc = rd_en & !buf_empty.
- Write accept: wr_acc = wr_en & (!buf_full | rd_en). A write while full is accepted only when a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] ← buf_in, and wr_ptr increments.
- On rd_acc: buf_out ← mem[rd_ptr], and rd_ptr increments. Otherwise buf_out holds its value.
- fifo_counter ← fifo_counter + wr_acc − rd_acc. It never exceeds DEPTH or goes below 0.
- When empty with rd_en & wr_en, only the write is accepted. There is no bypass: buf_out is unchanged and the count becomes 1.
- When full with rd_en & wr_en, both are accepted. The count stays DEPTH, and buf_out gets the oldest entry.
- Rejected requests leave all state unchanged.
- buf_empty, buf_full, almost_empty and almost_full are decoded combinationally from fifo_counter.

## Timing
- Reset (rst=0 at a clk edge) applies the following:
  - pointers = 0, fifo_counter = 0, buf_out = 0;
  - buf_empty = 1, buf_full = 0;
  - almost_empty = 1, almost_full = (AF_LEVEL==0, never legal) 0;
  - overflow = underflow = 0.
- Reset mid-operation discards all contents. It takes priority over any wr_en or rd_en in the same cycle.
- Read latency is 1 cycle. Data appears on buf_out at the edge that accepts rd_en.
- Write-to-read latency is 1 cycle. A word written at edge N is readable by a request sampled at edge N+1.
- Flags update in the cycle after the accepting edge, together with fifo_counter.

## Configuration
- Macro: FIFO_ERR_EN.
- Defined:
  - overflow sets on any cycle with wr_en & !wr_acc.
  - underflow sets on any cycle with rd_en & buf_empty.
  - Both flags are sticky until err_clr=1 or reset. Set wins over err_clr in the same cycle.
- Undefined:
  - err_clr, overflow and underflow ports and logic are absent.
  - Rejected requests are silently dropped.
  - All other behaviour is identical.

## Test plan
1. Reset, then write 0x01..0x10 (DEPTH=16), then read 16 times.
   - Response: buf_out = 0x01..0x10 in order. fifo_counter goes 16→0. buf_full is high after the 16th write and buf_empty is high after the 16th read.
2. Thresholds: write 13 → almost_full=0; write 14th → almost_full=1. Read down to 3 → almost_empty=0; read to 2 → almost_empty=1.
3. Full with wr_en & rd_en and buf_in=0xAA.
   - Response: count stays 16 and buf_out = oldest entry. After draining, 0xAA is the last word out.
4. Empty with wr_en & rd_en and buf_in=0x55.
   - Response: count=1 and buf_out unchanged (0 after reset). The next read returns 0x55.
5. Wrap-around: repeat 40 cycles of write-then-read with incrementing data. Every read matches the data written, and buf_empty=1 at the end.
6. FIFO_ERR_EN defined: write when full → overflow=1 and count stays 16; read when empty → underflow=1. err_clr for 1 cycle → both 0. Then pulse rst=0 mid-fill → count=0 and buf_out=0.
